// File: rtl/plot_arbiter_pkg.sv
// plot_arbiter_pkg: shared widths, screen geometry and the arbiter state enum
// for the framebuffer write-port arbiter (plot_arbiter) and its raster
// sub-module (rect_raster).
package plot_arbiter_pkg;

  localparam int X_W      = 8;    // pixel column width
  localparam int Y_W      = 7;    // pixel row width
  localparam int COLOR_W  = 3;    // VGA colour width
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } plot_arb_state_t;

endpackage

// File: rtl/rect_raster.sv
// rect_raster: cx/cy raster counter pair for one rectangle, with last-pixel
// detect and optional screen clipping.
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   i_clear              - return counters to pixel (0,0) when not stepping
//   i_step               - the pixel addressed now is being emitted; advance
//   i_x0/i_y0/i_w/i_h    - rectangle origin and size
//   o_x/o_y              - coordinate of the pixel addressed by the counters
//   o_visible            - pixel lies on screen (always 1 without clipping)
//   o_last               - addressed pixel is the final one (w-1, h-1)
//
// Build option: PLOT_ARBITER_CLIP_EN enables the on-screen check; without it
// coordinates wrap modulo 256/128 and every pixel is visible.
module rect_raster
  import plot_arbiter_pkg::*;
#(
  parameter int X_MAX = SCREEN_W,
  parameter int Y_MAX = SCREEN_H
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_clear,
  input  logic           i_step,
  input  logic [X_W-1:0] i_x0,
  input  logic [Y_W-1:0] i_y0,
  input  logic [X_W-1:0] i_w,
  input  logic [Y_W-1:0] i_h,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_visible,
  output logic           o_last
);

  logic [X_W-1:0] r_cx;
  logic [Y_W-1:0] r_cy;
  logic           w_row_end;

  assign w_row_end = (r_cx == i_w - X_W'(1));
  assign o_last    = w_row_end && (r_cy == i_h - Y_W'(1));

`ifdef PLOT_ARBITER_CLIP_EN
  // One extra bit on each sum so an off-screen pixel cannot wrap back on.
  logic [X_W:0] w_sum_x;
  logic [Y_W:0] w_sum_y;
  assign w_sum_x   = {1'b0, i_x0} + {1'b0, r_cx};
  assign w_sum_y   = {1'b0, i_y0} + {1'b0, r_cy};
  assign o_x       = w_sum_x[X_W-1:0];
  assign o_y       = w_sum_y[Y_W-1:0];
  assign o_visible = (w_sum_x < (X_W+1)'(X_MAX)) && (w_sum_y < (Y_W+1)'(Y_MAX));
`else
  assign o_x       = i_x0 + r_cx;
  assign o_y       = i_y0 + r_cy;
  assign o_visible = 1'b1;
`endif

  // Step has priority: the grant cycle both emits pixel (0,0) and is a
  // non-DRAW cycle, and the counters must advance past it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_step) begin
      if (w_row_end) begin
        r_cx <= '0;
        r_cy <= r_cy + Y_W'(1);
      end else begin
        r_cx <= r_cx + X_W'(1);
      end
    end else if (i_clear) begin
      r_cx <= '0;
      r_cy <= '0;
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin arbiter sharing the VGA framebuffer write port
// among N_REQ rectangle-drawing requesters. One pixel per clock, raster order.
//
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   req                - per-requester level request, held until its ack
//   req_x0/y0/w/h/color- packed rectangle fields, requester i at slice i
//   ack                - one-cycle completion pulse to the served requester
//   busy               - high whenever the FSM is not IDLE
//   plot_x/plot_y/color/plot - registered framebuffer write port
//   o_dbg_state        - current FSM state
//   o_dbg_rr_ptr       - current round-robin search start
//
// Handshake: a requester raises req and holds it with stable fields until
// the grant; fields are latched at the grant and may change afterwards. ack
// pulses once when the rectangle is finished, even if req dropped early.
//
// Build option: PLOT_ARBITER_CLIP_EN suppresses plot for off-screen pixels.
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int X_MAX = SCREEN_W,
  parameter  int Y_MAX = SCREEN_H,
  localparam int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [X_W*N_REQ-1:0]       req_x0,
  input  logic [Y_W*N_REQ-1:0]       req_y0,
  input  logic [X_W*N_REQ-1:0]       req_w,
  input  logic [Y_W*N_REQ-1:0]       req_h,
  input  logic [COLOR_W*N_REQ-1:0]   req_color,
  output logic [N_REQ-1:0]           ack,
  output logic                       busy,
  output logic [X_W-1:0]             plot_x,
  output logic [Y_W-1:0]             plot_y,
  output logic [COLOR_W-1:0]         color,
  output logic                       plot,
  output plot_arb_state_t            o_dbg_state,
  output logic [GW-1:0]              o_dbg_rr_ptr
);

  plot_arb_state_t    r_state, w_state_nxt;
  logic [GW-1:0]      r_rr_ptr, r_grant, w_grant;
  logic               w_any;
  int                 w_idx;
  logic [X_W-1:0]     r_x0, r_w, w_sel_x0, w_sel_w, w_base_x0, w_base_w, w_pix_x;
  logic [Y_W-1:0]     r_y0, r_h, w_sel_y0, w_sel_h, w_base_y0, w_base_h, w_pix_y;
  logic [COLOR_W-1:0] r_color, w_sel_color, w_base_color;
  logic               r_last, w_pix_last, w_pix_visible, w_zero;
  logic               w_emit, w_plot_nxt, w_busy_nxt;
  logic [N_REQ-1:0]   w_ack_nxt, w_onehot;

  assign o_dbg_state  = r_state;
  assign o_dbg_rr_ptr = r_rr_ptr;

  // First asserted req at or after r_rr_ptr, searching cyclically.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (req[w_idx] && !w_any) begin
        w_any   = 1'b1;
        w_grant = GW'(w_idx);
      end
    end
  end

  assign w_sel_x0    = req_x0[int'(w_grant)*X_W +: X_W];
  assign w_sel_y0    = req_y0[int'(w_grant)*Y_W +: Y_W];
  assign w_sel_w     = req_w[int'(w_grant)*X_W +: X_W];
  assign w_sel_h     = req_h[int'(w_grant)*Y_W +: Y_W];
  assign w_sel_color = req_color[int'(w_grant)*COLOR_W +: COLOR_W];
  assign w_zero      = (w_sel_w == '0) || (w_sel_h == '0);

  // The first pixel is registered in the grant cycle, before the latch
  // exists, so the raster reads the live fields while IDLE.
  assign w_base_x0    = (r_state == IDLE) ? w_sel_x0    : r_x0;
  assign w_base_y0    = (r_state == IDLE) ? w_sel_y0    : r_y0;
  assign w_base_w     = (r_state == IDLE) ? w_sel_w     : r_w;
  assign w_base_h     = (r_state == IDLE) ? w_sel_h     : r_h;
  assign w_base_color = (r_state == IDLE) ? w_sel_color : r_color;

  rect_raster #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_raster (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (r_state != DRAW),
    .i_step    (w_emit),
    .i_x0      (w_base_x0),
    .i_y0      (w_base_y0),
    .i_w       (w_base_w),
    .i_h       (w_base_h),
    .o_x       (w_pix_x),
    .o_y       (w_pix_y),
    .o_visible (w_pix_visible),
    .o_last    (w_pix_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state. DONE lasts one cycle after a drawn rectangle (ack is raised
  // on entry); a zero-size rectangle enters with ack low and spends one
  // extra DONE cycle raising it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = w_zero ? DONE : DRAW;
      DRAW:    if (r_last) w_state_nxt = DONE;
      DONE:    if (ack != '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output next-values; r_last marks that the pixel on the port is final.
  always_comb begin
    w_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;
    w_emit     = ((r_state == IDLE) && w_any && !w_zero) ||
                 ((r_state == DRAW) && !r_last);
    w_plot_nxt = w_emit && w_pix_visible;
    w_ack_nxt  = '0;
    if (((r_state == DRAW) && r_last) || ((r_state == DONE) && (ack == '0)))
      w_ack_nxt = w_onehot;
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      plot     <= 1'b0;
      ack      <= '0;
      busy     <= 1'b0;
      plot_x   <= '0;
      plot_y   <= '0;
      color    <= '0;
      r_last   <= 1'b0;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_color  <= '0;
    end else begin
      plot   <= w_plot_nxt;
      ack    <= w_ack_nxt;
      busy   <= w_busy_nxt;
      r_last <= w_emit && w_pix_last;
      if (w_emit) begin
        plot_x <= w_pix_x;
        plot_y <= w_pix_y;
        color  <= w_base_color;
      end
      if ((r_state == IDLE) && w_any) begin
        r_grant <= w_grant;
        r_x0    <= w_sel_x0;
        r_y0    <= w_sel_y0;
        r_w     <= w_sel_w;
        r_h     <= w_sel_h;
        r_color <= w_sel_color;
      end
      if ((r_state == DONE) && (ack != '0))
        r_rr_ptr <= (r_grant == GW'(N_REQ-1)) ? '0 : r_grant + GW'(1);
    end
  end

endmodule
